// File: rtl/alu_rr_arbiter_if.sv
// Request, ALU and response signals shared between the arbiter and its clients.
interface alu_rr_arbiter_if #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned W    = 4,
  parameter int unsigned IDW  = 3
);
  // Requester side
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ*3-1:0] req_op;

  // Shared ALU side
  logic [W-1:0]      alu_a;
  logic [W-1:0]      alu_b;
  logic [2:0]        alu_op;
  logic [W-1:0]      alu_result;
  logic              alu_zero;

  // Response side
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_result;
  logic              rsp_zero;

  // Arbiter view
  modport slave (
    input  req_valid, req_a, req_b, req_op, alu_result, alu_zero, rsp_ready,
    output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_result, rsp_zero
  );

  // Client / ALU / consumer view
  modport master (
    output req_valid, req_a, req_b, req_op, alu_result, alu_zero, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_result, rsp_zero
  );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between NREQ requesters.
// Each operation walks IDLE (grant) -> EXEC (ALU settles) -> RESP (hold until taken).
module alu_rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned W    = 4,
  parameter int unsigned IDW  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_rr_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [W-1:0]   alu_a_q, alu_a_d;
  logic [W-1:0]   alu_b_q, alu_b_d;
  logic [2:0]     alu_op_q, alu_op_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [W-1:0]   rsp_result_q, rsp_result_d;
  logic           rsp_zero_q, rsp_zero_d;

  logic            grant_any;
  logic [IDW-1:0]  grant_idx;
  logic [NREQ-1:0] grant_onehot;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic [2:0]      sel_op;

  // Round-robin pick: first valid requester after ptr, wrapping, plus its operand fields
  always_comb begin
    grant_any    = 1'b0;
    grant_idx    = '0;
    grant_onehot = '0;
    sel_a        = '0;
    sel_b        = '0;
    sel_op       = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!grant_any && bus.req_valid[j] && (j == (32'(ptr_q) + i) % NREQ)) begin
          grant_any       = 1'b1;
          grant_idx       = IDW'(j);
          grant_onehot[j] = 1'b1;
          sel_a           = bus.req_a[j*W +: W];
          sel_b           = bus.req_b[j*W +: W];
          sel_op          = bus.req_op[j*3 +: 3];
        end
      end
    end
  end

  // Accept is only offered from IDLE, and never while reset is held
  always_comb begin
    bus.req_ready = '0;
    if (rst_n && (state_q == StIdle)) begin
      bus.req_ready = grant_onehot;
    end
  end

  // Next-state and register updates for the IDLE -> EXEC -> RESP sequence
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    unique case (state_q)
      StIdle: begin
        if (grant_any) begin
          alu_a_d  = sel_a;
          alu_b_d  = sel_b;
          alu_op_d = sel_op;
          rsp_id_d = grant_idx;
          ptr_d    = grant_idx;
          state_d  = StExec;
        end
      end
      StExec: begin
        rsp_result_d = bus.alu_result;
        rsp_zero_d   = bus.alu_zero;
        rsp_valid_d  = 1'b1;
        state_d      = StResp;
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset drops any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      ptr_q        <= IDW'(NREQ - 1);
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: table of single operations, fairness run, response stall
// and reset during EXEC. Responses are checked against a queue of expected results.
module tb_alu_rr_arbiter;

  localparam int unsigned NREQ = 2;
  localparam int unsigned W    = 4;
  localparam int unsigned IDW  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_rr_arbiter_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();

  alu_rr_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Stand-in for the external ALU: add, sub, and, or, xor; other opcodes return 0
  always_comb begin
    case (bus.alu_op)
      3'b000:  bus.alu_result = bus.alu_a + bus.alu_b;
      3'b001:  bus.alu_result = bus.alu_a - bus.alu_b;
      3'b010:  bus.alu_result = bus.alu_a & bus.alu_b;
      3'b011:  bus.alu_result = bus.alu_a | bus.alu_b;
      3'b100:  bus.alu_result = bus.alu_a ^ bus.alu_b;
      default: bus.alu_result = '0;
    endcase
    bus.alu_zero = (bus.alu_result == '0);
  end

  typedef struct {
    logic [NREQ-1:0] vmask;
    int              id;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [2:0]      op;
    logic [W-1:0]    res;
    logic            zero;
  } vec_t;

  typedef struct {
    logic [IDW-1:0] id;
    logic [W-1:0]   res;
    logic           zero;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[8];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
    bus.req_op[i*3 +: 3] = op;
  endtask

  // Called just after a negedge in IDLE with rsp_ready=1; runs one full operation
  task automatic do_op(input logic [NREQ-1:0] vmask, input int id, input logic [W-1:0] res,
                       input logic zero, input string tag);
    exp_t e;
    bus.req_valid = vmask;
    #1;
    check({tag, " req_ready"}, 32'(bus.req_ready), 32'(1) << id);
    e.id   = IDW'(id);
    e.res  = res;
    e.zero = zero;
    sb_q.push_back(e);
    @(posedge clk);
    #1 bus.req_valid = '0;
    @(negedge clk);
    check({tag, " exec rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, " exec req_ready"}, 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check({tag, " latency rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    @(negedge clk);
    check({tag, " back idle"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  // Response monitor: each new response is compared with the oldest expectation
  initial begin
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
      end else begin
        if (bus.rsp_valid && !prev_v) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexpected: got id %0d result %0h, expected no response",
                     bus.rsp_id, bus.rsp_result);
          end else begin
            e = sb_q.pop_front();
            check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
            check("rsp_result", 32'(bus.rsp_result), 32'(e.res));
            check("rsp_zero", 32'(bus.rsp_zero), 32'(e.zero));
          end
        end
        prev_v = bus.rsp_valid;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{vmask: 2'b01, id: 0, a: 4'd3,  b: 4'd4,  op: 3'b000, res: 4'd7, zero: 1'b0};
    vecs[1] = '{vmask: 2'b01, id: 0, a: 4'd5,  b: 4'd5,  op: 3'b001, res: 4'd0, zero: 1'b1};
    vecs[2] = '{vmask: 2'b10, id: 1, a: 4'd5,  b: 4'd5,  op: 3'b111, res: 4'd0, zero: 1'b1};
    vecs[3] = '{vmask: 2'b10, id: 1, a: 4'd15, b: 4'd1,  op: 3'b000, res: 4'd0, zero: 1'b1};
    vecs[4] = '{vmask: 2'b01, id: 0, a: 4'd9,  b: 4'd3,  op: 3'b001, res: 4'd6, zero: 1'b0};
    vecs[5] = '{vmask: 2'b10, id: 1, a: 4'd12, b: 4'd10, op: 3'b010, res: 4'd8, zero: 1'b0};
    // Both valid with ptr at 1: requester 0 wins, then requester 1
    vecs[6] = '{vmask: 2'b11, id: 0, a: 4'd6,  b: 4'd3,  op: 3'b100, res: 4'd5, zero: 1'b0};
    vecs[7] = '{vmask: 2'b11, id: 1, a: 4'd2,  b: 4'd0,  op: 3'b101, res: 4'd0, zero: 1'b1};

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset req_ready", 32'(bus.req_ready), 32'd0);
    check("reset rsp", {27'd0, bus.rsp_valid, bus.rsp_id, bus.rsp_zero}, 32'd0);
    check("reset rsp_result", 32'(bus.rsp_result), 32'd0);
    check("reset alu", {21'd0, bus.alu_a, bus.alu_b, bus.alu_op}, 32'd0);
    rst_n = 1'b1;

    // Table of single operations
    for (int i = 0; i < 8; i++) begin
      set_req(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op);
      do_op(vecs[i].vmask, vecs[i].id, vecs[i].res, vecs[i].zero, $sformatf("vec%0d", i));
    end

    // Fairness: both requesters held valid, grants alternate 0,1,0,1 every 3 cycles
    begin
      int exp_g;
      int last;
      int ngrants;
      exp_t e;
      exp_g   = 0;
      last    = -1;
      ngrants = 0;
      set_req(0, 4'd1, 4'd1, 3'b000);
      set_req(1, 4'd2, 4'd3, 3'b000);
      bus.req_valid = 2'b11;
      for (int c = 0; c < 12; c++) begin
        #1;
        if (bus.req_ready != '0) begin
          check("rr grant", 32'(bus.req_ready), 32'(1) << exp_g);
          if (last >= 0) check("rr spacing", 32'(c - last), 32'd3);
          e.id   = IDW'(exp_g);
          e.res  = (exp_g == 0) ? 4'd2 : 4'd5;
          e.zero = 1'b0;
          sb_q.push_back(e);
          last  = c;
          exp_g = 1 - exp_g;
          ngrants++;
        end
        @(negedge clk);
      end
      bus.req_valid = '0;
      check("rr grant count", 32'(ngrants), 32'd4);
    end

    // Response stall: rsp_* held and req_ready low while the consumer is not ready
    @(negedge clk);
    set_req(0, 4'd7, 4'd1, 3'b000);
    begin
      exp_t e;
      bus.rsp_ready = 1'b0;
      bus.req_valid = 2'b01;
      #1;
      check("stall req_ready", 32'(bus.req_ready), 32'd1);
      e.id   = '0;
      e.res  = 4'd8;
      e.zero = 1'b0;
      sb_q.push_back(e);
      @(posedge clk);
      #1 bus.req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      bus.req_valid = 2'b11;
      for (int k = 0; k < 5; k++) begin
        #1;
        check("stall rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("stall rsp_fields", {24'd0, bus.rsp_id, bus.rsp_result, bus.rsp_zero},
              {24'd0, 3'd0, 4'd8, 1'b0});
        check("stall req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
      end
      bus.req_valid = '0;
      #1 bus.rsp_ready = 1'b1;
      @(negedge clk);
      check("stall release idle", 32'(bus.rsp_valid), 32'd0);
    end

    // Reset during EXEC drops the operation; afterwards requester 0 has priority
    set_req(0, 4'd1, 4'd2, 3'b000);
    bus.req_valid = 2'b01;
    #1;
    check("rstexec req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1 bus.req_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rstexec rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rstexec alu", {21'd0, bus.alu_a, bus.alu_b, bus.alu_op}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rstexec no response", 32'(bus.rsp_valid), 32'd0);
    set_req(0, 4'd2, 4'd2, 3'b001);
    set_req(1, 4'd9, 4'd9, 3'b000);
    do_op(2'b11, 0, 4'd0, 1'b1, "post_reset");

    check("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
